// File: rtl/perf_traffic_gen.sv
// Credit-paced AXI-stream packet generator: per-class credit buckets, round-robin
// grant among eligible classes, header-stamped first beat followed by zero payload.
module perf_traffic_gen #(
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8,
    parameter int NUM_CLASS       = 3,
    parameter int CREDIT_MAX      = 65535
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [NUM_CLASS*16-1:0]      cfg_pk_len,
    input  logic [NUM_CLASS*8-1:0]       cfg_rate,
    output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    output logic [4:0]                   m_flow_class,
    output logic [15:0]                  m_pk_len,
    output logic [31:0]                  tx_pk_count,
    output logic [47:0]                  tx_frame_count
);

    localparam int          KEEP_LOG   = $clog2(AXIS_KEEP_WIDTH);
    localparam logic [20:0] CREDIT_CAP = 21'(CREDIT_MAX);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state;
    state_t              state_next;

    logic [19:0]         credit       [NUM_CLASS];
    logic [19:0]         credit_next  [NUM_CLASS];
    logic [20:0]         credit_sum   [NUM_CLASS];
    logic [15:0]         class_len    [NUM_CLASS];
    logic [15:0]         class_frames [NUM_CLASS];
    logic [NUM_CLASS-1:0] eligible;

    logic                grant;
    logic [4:0]          grant_class;
    logic [4:0]          rr_pos;
    logic [4:0]          last_grant;

    logic [15:0]         cur_len;
    logic [15:0]         cur_frames;
    logic [4:0]          cur_class;
    logic [31:0]         cur_seq;
    logic [31:0]         seq;
    logic [15:0]         beat_idx;
    logic                beat_accept;
    logic                last_beat;

    // Frame count is ceil(len / KEEP): whole beats plus one if any residue bytes remain.
    always_comb begin
        for (int c = 0; c < NUM_CLASS; c++) begin
            class_len[c]    = cfg_pk_len[c*16 +: 16];
            class_frames[c] = (class_len[c] >> KEEP_LOG) + 16'(|class_len[c][KEEP_LOG-1:0]);
            eligible[c]     = (class_len[c] != 16'd0) && (credit[c] >= {class_frames[c], 4'b0000});
        end
    end

    // Round-robin search: offset i visits class (last_grant + 1 + i) mod NUM_CLASS.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        grant       = 1'b0;
        grant_class = 5'd0;
        rr_pos      = 5'd0;
        if (state == IDLE && enable) begin
            for (int i = 0; i < NUM_CLASS; i++) begin
                rr_pos = last_grant + 5'(1 + i);
                if (rr_pos >= 5'(NUM_CLASS))
                    rr_pos = rr_pos - 5'(NUM_CLASS);
                for (int c = 0; c < NUM_CLASS; c++) begin
                    if (!grant && eligible[c] && rr_pos == 5'(c)) begin
                        grant       = 1'b1;
                        grant_class = 5'(c);
                    end
                end
            end
        end
    end

    // A grant can never underflow: eligibility already guarantees credit >= cost.
    always_comb begin
        for (int c = 0; c < NUM_CLASS; c++) begin
            credit_sum[c] = {1'b0, credit[c]} + 21'(cfg_rate[c*8 +: 8]);
            if (grant && grant_class == 5'(c))
                credit_sum[c] = credit_sum[c] - {1'b0, class_frames[c], 4'b0000};
            credit_next[c] = (credit_sum[c] > CREDIT_CAP) ? CREDIT_CAP[19:0] : credit_sum[c][19:0];
        end
    end

    assign beat_accept = (state == SEND) && m_axis_tready;
    assign last_beat   = (beat_idx == cur_frames - 16'd1);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            // NOTE: clocked state uses non-blocking assignment so every flop samples pre-edge values.
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (grant) state_next = SEND;
            SEND: if (beat_accept && last_beat) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the credit array is a handful of flops, not a RAM, so it is reset like any register.
            for (int c = 0; c < NUM_CLASS; c++)
                credit[c] <= 20'd0;
        end else begin
            for (int c = 0; c < NUM_CLASS; c++)
                credit[c] <= credit_next[c];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant     <= 5'(NUM_CLASS - 1);
            seq            <= 32'd0;
            cur_len        <= 16'd0;
            cur_frames     <= 16'd0;
            cur_class      <= 5'd0;
            cur_seq        <= 32'd0;
            beat_idx       <= 16'd0;
            tx_pk_count    <= 32'd0;
            tx_frame_count <= 48'd0;
        end else begin
            if (grant) begin
                last_grant <= grant_class;
                cur_class  <= grant_class;
                cur_len    <= class_len[grant_class[$clog2(NUM_CLASS+1)-1:0]];
                cur_frames <= class_frames[grant_class[$clog2(NUM_CLASS+1)-1:0]];
                cur_seq    <= seq;
                seq        <= seq + 32'd1;
                beat_idx   <= 16'd0;
            end
            if (beat_accept) begin
                tx_frame_count <= tx_frame_count + 48'd1;
                if (last_beat)
                    tx_pk_count <= tx_pk_count + 32'd1;
                else
                    beat_idx <= beat_idx + 16'd1;
            end
        end
    end

    // Outputs are decoded from latched packet state, so they hold steady through back-pressure.
    always_comb begin
        m_axis_tvalid = (state == SEND);
        m_axis_tlast  = (state == SEND) && last_beat;
        m_flow_class  = cur_class;
        m_pk_len      = cur_len;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        if (state == SEND) begin
            if (beat_idx == 16'd0) begin
                m_axis_tdata[15:0]  = cur_len;
                m_axis_tdata[20:16] = cur_class;
                m_axis_tdata[63:32] = cur_seq;
            end
            m_axis_tkeep = '1;
            if (last_beat && cur_len[KEEP_LOG-1:0] != '0) begin
                for (int i = 0; i < AXIS_KEEP_WIDTH; i++)
                    m_axis_tkeep[i] = (i < int'(cur_len[KEEP_LOG-1:0]));
            end
        end
    end

endmodule

// File: tb/tb_perf_traffic_gen.sv
// Self-checking bench for perf_traffic_gen: expected beats are queued as stimulus is
// driven and compared beat-by-beat (including during back-pressure) by a monitor.
module tb_perf_traffic_gen;

    localparam int DW = 512;
    localparam int KW = 64;
    localparam int NC = 3;
    localparam logic [63:0] ALL1 = {64{1'b1}};

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [NC*16-1:0]  cfg_pk_len;
    logic [NC*8-1:0]   cfg_rate;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic              m_axis_tvalid;
    logic              m_axis_tlast;
    logic              m_axis_tready;
    logic [4:0]        m_flow_class;
    logic [15:0]       m_pk_len;
    logic [31:0]       tx_pk_count;
    logic [47:0]       tx_frame_count;

    perf_traffic_gen #(
        .AXIS_DATA_WIDTH (DW),
        .AXIS_KEEP_WIDTH (KW),
        .NUM_CLASS       (NC),
        .CREDIT_MAX      (65535)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .cfg_pk_len     (cfg_pk_len),
        .cfg_rate       (cfg_rate),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .m_flow_class   (m_flow_class),
        .m_pk_len       (m_pk_len),
        .tx_pk_count    (tx_pk_count),
        .tx_frame_count (tx_frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [4:0]    cls;
        logic [15:0]   len;
    } beat_t;

    typedef struct {
        logic [15:0] len;
        int          nbeats;
        logic [63:0] last_keep;
    } vec_t;

    beat_t       exp_q[$];
    logic [31:0] exp_seq;
    int          exp_pks;
    int          exp_frames;
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_packet(input logic [4:0] cls, input logic [15:0] len,
                               input int nbeats, input logic [63:0] last_keep);
        for (int b = 0; b < nbeats; b++) begin
            beat_t e;
            e.data = '0;
            if (b == 0) begin
                e.data[15:0]  = len;
                e.data[20:16] = cls;
                e.data[63:32] = exp_seq;
            end
            e.keep = (b == nbeats - 1) ? last_keep : ALL1;
            e.last = (b == nbeats - 1);
            e.cls  = cls;
            e.len  = len;
            exp_q.push_back(e);
        end
        exp_seq    = exp_seq + 32'd1;
        exp_pks    = exp_pks + 1;
        exp_frames = exp_frames + nbeats;
    endtask

    task automatic set_cls(input int c, input logic [15:0] len, input logic [7:0] rate);
        cfg_pk_len[c*16 +: 16] = len;
        cfg_rate[c*8 +: 8]     = rate;
    endtask

    task automatic wait_valid(input int budget, output int waited);
        waited = 0;
        while (!m_axis_tvalid && waited < budget) begin
            tick();
            waited++;
        end
        check("wait_tvalid", m_axis_tvalid, 1);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (m_axis_tvalid && n < budget) begin
            tick();
            n++;
        end
        check("wait_idle", m_axis_tvalid, 0);
    endtask

    task automatic run_pkt();
        int w;
        enable = 1'b1;
        wait_valid(300, w);
        enable = 1'b0;
        wait_idle(100);
    endtask

    task automatic hold_reset();
        rst    = 1'b1;
        enable = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) tick();
        exp_q.delete();
        exp_seq    = 32'd0;
        exp_pks    = 0;
        exp_frames = 0;
    endtask

    // Monitor: every presented beat must match the queue head; popped only on acceptance.
    always @(negedge clk) begin
        if (!rst && m_axis_tvalid) begin
            check("sb_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                check("tdata",  m_axis_tdata,  exp_q[0].data);
                check("tkeep",  m_axis_tkeep,  exp_q[0].keep);
                check("tlast",  m_axis_tlast,  exp_q[0].last);
                check("class",  m_flow_class,  exp_q[0].cls);
                check("pk_len", m_pk_len,      exp_q[0].len);
                if (m_axis_tready)
                    void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   w;
        logic [31:0] p0;

        vecs[0] = '{16'd100,  2, 64'h0000_000F_FFFF_FFFF};
        vecs[1] = '{16'd1,    1, 64'h0000_0000_0000_0001};
        vecs[2] = '{16'd128,  2, ALL1};
        vecs[3] = '{16'd200,  4, 64'h0000_0000_0000_00FF};
        vecs[4] = '{16'd65,   2, 64'h0000_0000_0000_0001};
        vecs[5] = '{16'd1000, 16, 64'h0000_00FF_FFFF_FFFF};

        cfg_pk_len = '0;
        cfg_rate   = '0;
        set_cls(0, 16'd64, 8'd255);
        hold_reset();

        // Reset state
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast",  m_axis_tlast,  0);
        check("rst_tdata",  m_axis_tdata,  0);
        check("rst_tkeep",  m_axis_tkeep,  0);
        check("rst_class",  m_flow_class,  0);
        check("rst_len",    m_pk_len,      0);
        check("rst_pk_cnt", tx_pk_count,   0);
        check("rst_fr_cnt", tx_frame_count, 0);

        // First packet: one cycle to build credit, grant on the next edge
        push_packet(5'd0, 16'd64, 1, ALL1);
        rst    = 1'b0;
        enable = 1'b1;
        wait_valid(20, w);
        enable = 1'b0;
        check("first_grant_latency", w, 2);
        wait_idle(20);
        check("pk_count", tx_pk_count,    exp_pks);
        check("fr_count", tx_frame_count, exp_frames);

        // Table of lengths on class 0
        foreach (vecs[i]) begin
            set_cls(0, vecs[i].len, 8'd255);
            push_packet(5'd0, vecs[i].len, vecs[i].nbeats, vecs[i].last_keep);
            run_pkt();
            check("vec_pk_count", tx_pk_count,    exp_pks);
            check("vec_fr_count", tx_frame_count, exp_frames);
        end

        // Enable low: no further packets even with full credit
        repeat (10) tick();
        check("enable_low_hold", tx_pk_count, exp_pks);

        // Back-pressure for 5 cycles on beat 1, with a cfg change mid-packet
        set_cls(0, 16'd200, 8'd255);
        push_packet(5'd0, 16'd200, 4, 64'hFF);
        enable = 1'b1;
        wait_valid(300, w);
        enable = 1'b0;
        tick();
        m_axis_tready = 1'b0;
        set_cls(0, 16'd64, 8'd255);
        repeat (5) tick();
        check("stall_frames", tx_frame_count, exp_frames - 3);
        m_axis_tready = 1'b1;
        wait_idle(50);
        check("stall_pk_count", tx_pk_count,    exp_pks);
        check("stall_fr_count", tx_frame_count, exp_frames);
        push_packet(5'd0, 16'd64, 1, ALL1);
        run_pkt();
        check("newcfg_fr_count", tx_frame_count, exp_frames);
        check("sb_drained_a", exp_q.size(), 0);

        // Round robin across three classes with distinct lengths
        set_cls(1, 16'd100, 8'd255);
        set_cls(2, 16'd30,  8'd255);
        hold_reset();
        for (int r = 0; r < 2; r++) begin
            push_packet(5'd0, 16'd64,  1, ALL1);
            push_packet(5'd1, 16'd100, 2, 64'h0000_000F_FFFF_FFFF);
            push_packet(5'd2, 16'd30,  1, 64'h0000_0000_3FFF_FFFF);
        end
        rst    = 1'b0;
        enable = 1'b1;
        begin
            int n = 0;
            while (tx_pk_count != 32'd6 && n < 300) begin
                tick();
                n++;
            end
        end
        enable = 1'b0;
        check("rr_pk_count", tx_pk_count, 6);
        wait_idle(20);
        repeat (3) tick();
        check("rr_fr_count", tx_frame_count, 8);
        check("sb_drained_rr", exp_q.size(), 0);

        // Reset on beat 1 of a 4-beat class-0 packet
        set_cls(0, 16'd256, 8'd255);
        set_cls(1, 16'd0,   8'd0);
        set_cls(2, 16'd0,   8'd0);
        push_packet(5'd0, 16'd256, 4, ALL1);
        enable = 1'b1;
        wait_valid(300, w);
        enable = 1'b0;
        tick();
        rst = 1'b1;
        m_axis_tready = 1'b0;
        tick();
        check("rst_send_tvalid", m_axis_tvalid,  0);
        check("rst_send_pk",     tx_pk_count,    0);
        check("rst_send_fr",     tx_frame_count, 0);
        exp_q.delete();
        exp_seq    = 32'd0;
        exp_pks    = 0;
        exp_frames = 0;
        set_cls(0, 16'd64, 8'd255);
        set_cls(1, 16'd64, 8'd255);
        set_cls(2, 16'd64, 8'd255);
        m_axis_tready = 1'b1;
        rst = 1'b0;
        push_packet(5'd0, 16'd64, 1, ALL1);
        run_pkt();
        check("post_rst_pk", tx_pk_count, 1);
        check("sb_drained_rst", exp_q.size(), 0);

        // Steady-state pacing: rate 4 at 16 credits per packet is one packet every 4 cycles
        set_cls(0, 16'd64, 8'd4);
        set_cls(1, 16'd0,  8'd0);
        set_cls(2, 16'd0,  8'd0);
        hold_reset();
        for (int k = 0; k < 40; k++)
            push_packet(5'd0, 16'd64, 1, ALL1);
        rst    = 1'b0;
        enable = 1'b1;
        repeat (40) tick();
        p0 = tx_pk_count;
        repeat (64) tick();
        check("rate_64_cycles", tx_pk_count - p0, 16);
        enable = 1'b0;
        wait_idle(20);
        exp_q.delete();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/perf_traffic_gen.md
PERF_TRAFFIC_GEN -- requirements
Module: perf_traffic_gen

Interface
REQ-001 SHALL have parameter AXIS_DATA_WIDTH, default 512, meaning tdata width in bits (power of 2, ≥128).
REQ-002 SHALL have parameter AXIS_KEEP_WIDTH, default AXIS_DATA_WIDTH/8, meaning bytes per beat.
REQ-003 SHALL have parameter NUM_CLASS, default 3, meaning number of flow classes (1..5).
REQ-004 SHALL have parameter CREDIT_MAX, default 65535, meaning credit saturation value in 1/16-frame units.
REQ-005 SHALL have port clk, input, 1, meaning clock; all logic on posedge.
REQ-006 SHALL have port rst, input, 1, meaning synchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1, meaning packet starts are permitted.
REQ-008 SHALL have port cfg_pk_len, input, NUM_CLASS*16, meaning per-class packet length in bytes; a slice equal to 0 disables that class.
REQ-009 SHALL have port cfg_rate, input, NUM_CLASS*8, meaning per-class credit added per cycle, in 1/16 frame.
REQ-010 SHALL have ports m_axis_tdata, tkeep, tvalid and tlast as outputs of width DATA, KEEP, 1 and 1, plus m_axis_tready as a 1-bit input, forming an AXI stream master.
REQ-011 SHALL have port m_flow_class, output, 5, meaning the class of the current packet.
REQ-012 SHALL have port m_pk_len, output, 16, meaning the length of the current packet.
REQ-013 SHALL have ports tx_pk_count, output, 32, and tx_frame_count, output, 48, meaning packets and beats accepted downstream.

Function
REQ-014 SHALL keep one 20-bit credit register per class; every cycle credit_next = min(credit + cfg_rate[c] − deduct[c], CREDIT_MAX).
REQ-015 SHALL compute nframes = ceil(len/AXIS_KEEP_WIDTH) by shift and low-bit OR, with no divider.
REQ-016 SHALL mark class c eligible when cfg_pk_len[c] != 0 and credit[c] ≥ nframes*16, using registered credit values.
REQ-017 SHALL implement a two-state FSM, IDLE and SEND.
REQ-018 In IDLE with enable=1 and ≥1 eligible class, SHALL grant round-robin starting at last_grant+1 mod NUM_CLASS, latch class, len and nframes, deduct nframes*16 from that class in the same cycle, and enter SEND.
REQ-019 In SEND SHALL assert tvalid continuously; a beat advances only when tvalid&&tready.
REQ-020 While tvalid=1 and tready=0, tdata, tkeep, tlast, m_flow_class and m_pk_len SHALL hold stable.
REQ-021 Beat 0 tdata SHALL be: [15:0]=len, [20:16]=class, [63:32]=global packet sequence number (wraps at 2^32), all other bits 0; later beats SHALL be all-zero.
REQ-022 tkeep SHALL be all ones except on the last beat, where exactly the low (len − (nframes−1)*KEEP) bits are set.
REQ-023 tlast SHALL be 1 only on beat nframes−1; acceptance of the last beat SHALL return the FSM to IDLE, giving a minimum of 1 idle cycle between packets.
REQ-024 m_flow_class and m_pk_len SHALL be valid and constant from the first beat through the last beat of a packet.
REQ-025 Deassertion of enable during SEND SHALL let the current packet finish; no new packet SHALL start while enable=0.
REQ-026 cfg changes SHALL affect only packets granted after the change; latched len and class SHALL be unaffected.
REQ-027 tx_frame_count SHALL increment on each accepted beat and tx_pk_count on each accepted tlast beat; both SHALL wrap.
REQ-028 Credit SHALL accrue while enable=0, subject to saturation at CREDIT_MAX.

Reset
REQ-029 On rst, all outputs, counters, credits, the sequence number and last_grant=NUM_CLASS−1 SHALL reset to 0 and the FSM to IDLE, so the first grant prefers class 0.
REQ-030 rst during SEND SHALL drop tvalid on the next cycle, abandoning the packet with no tlast.

Verification
REQ-031 KEEP=64, class0 len=64, rate=255, tready=1, after 1 cycle of credit -> one beat, tkeep all ones, tlast=1, tdata[15:0]=64, [20:16]=0, seq=0.
REQ-032 len=100 -> 2 beats; beat1 tkeep=0x0000000FFFFFFFFF with tlast=1; tx_frame_count +2, tx_pk_count +1.
REQ-033 tready held 0 for 5 cycles mid-packet -> all outputs stable; no beat lost or duplicated.
REQ-034 class0 len=64, rate=4 (0.25 frame/cycle), steady state -> exactly 1 packet per 4 cycles over 64 cycles (16 packets).
REQ-035 3 classes, len=64, rate=255 -> grant order 0,1,2,0,1,2; seq increments 0..5.
REQ-036 rst asserted on beat 1 of a 4-beat packet -> tvalid=0 next cycle, counters=0, next packet is class 0 with seq=0.
